// File: rtl/pfd_cp_pkg.sv
// pfd_cp_pkg: shared state encoding, default parameters and the millivolt-to-code helper
package pfd_cp_pkg;
   typedef enum logic [1:0] {PFD_IDLE, PFD_UP, PFD_DN} pfd_state_t;
   localparam int PFD_VW          = 16;
   localparam int PFD_IC_CODE     = 32768;
   localparam int PFD_ICP_STEP    = 64;
   localparam int PFD_SYNC_STAGES = 2;
   localparam int VDD_MV          = 3000;
   // Rounds to nearest code so that VDD/2 lands exactly on the initial-condition code.
   function automatic logic [PFD_VW-1:0] v2code(input int mv);
      int c;
      c = (mv * ((1 << PFD_VW) - 1) + VDD_MV / 2) / VDD_MV;
      return c[PFD_VW-1:0];
   endfunction
endpackage

// File: rtl/pfd_cp_sampled_edge_sync.sv
// edge_sync: multi-flop synchronizer followed by a one-cycle rising-edge detector
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise_pulse
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end
   assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/pfd_cp_sampled.sv
// pfd_cp_sampled: tri-state PFD driving a charge pump into a saturating capacitor integrator
module pfd_cp_sampled
   import pfd_cp_pkg::*;
#(
   parameter int VW          = PFD_VW,
   parameter int IC_CODE     = PFD_IC_CODE,
   parameter int ICP_STEP    = PFD_ICP_STEP,
   parameter int SYNC_STAGES = PFD_SYNC_STAGES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          d,
   input  logic          refclk,
   input  logic          fbclk,
   output logic          up,
   output logic          down,
   output logic [VW-1:0] vctrl
);
   logic                   w_ref_edge, w_fb_edge;
   pfd_state_t             r_st, w_nxt;
   logic                   r_up, r_dn;
   logic [VW-1:0]          r_vctrl, w_vnxt;
   logic [VW:0]            w_sum;
   logic signed [VW+1:0]   w_dif;
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref (
      .clk(clk), .rst(rst), .async_in(refclk), .rise_pulse(w_ref_edge)
   );
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb (
      .clk(clk), .rst(rst), .async_in(fbclk), .rise_pulse(w_fb_edge)
   );
   // Coincident edges model both PFD flops setting and clearing in the same cycle.
   always_comb begin
      w_nxt = (w_ref_edge & w_fb_edge) ? PFD_IDLE :
              (r_st == PFD_IDLE) ? ((w_ref_edge & d) ? PFD_UP : (w_fb_edge & d) ? PFD_DN : PFD_IDLE) :
              (r_st == PFD_UP)   ? (w_fb_edge ? PFD_IDLE : PFD_UP) :
              (r_st == PFD_DN)   ? (w_ref_edge ? PFD_IDLE : PFD_DN) : PFD_IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_st <= PFD_IDLE;
         r_up <= 1'b0;
         r_dn <= 1'b0;
      end else begin
         r_st <= w_nxt;
         r_up <= (w_nxt == PFD_UP);
         r_dn <= (w_nxt == PFD_DN);
      end
   end
   always_comb begin
      w_sum  = {1'b0, r_vctrl} + (VW+1)'(ICP_STEP);
      w_dif  = $signed({2'b00, r_vctrl}) - $signed((VW+2)'(ICP_STEP));
      w_vnxt = r_up ? ((w_sum > (VW+1)'((1 << VW) - 1)) ? '1 : w_sum[VW-1:0]) :
               r_dn ? ((w_dif < 0) ? '0 : w_dif[VW-1:0]) : r_vctrl;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vctrl <= VW'(IC_CODE);
      else     r_vctrl <= w_vnxt;
   end
   assign up    = r_up;
   assign down  = r_dn;
   assign vctrl = r_vctrl;
endmodule

// File: tb/tb_pfd_cp_sampled.sv
// tb_pfd_cp_sampled: directed scoreboard bench for the PFD / charge-pump model
module tb_pfd_cp_sampled;
   import pfd_cp_pkg::*;
   logic        clk = 0, rst = 1, d = 1, refclk = 0, fbclk = 0;
   logic        up, down;
   logic [15:0] vctrl;
   int          checks = 0, errors = 0;
   typedef struct {string tag; logic [31:0] val;} exp_t;
   exp_t sb[$];

   pfd_cp_sampled dut (
      .clk(clk), .rst(rst), .d(d), .refclk(refclk), .fbclk(fbclk),
      .up(up), .down(down), .vctrl(vctrl)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] val);
      sb.push_back('{tag, val});
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0d expected none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; refclk = 0; fbclk = 0; d = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);
   endtask

   // Sample outputs, then drive inputs, once per negedge.
   task automatic pulse_run(input int ref_at, input int fb_at, input int n, output int ups, output int dns);
      ups = 0; dns = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ups += int'(up); dns += int'(down);
         if (i == ref_at) refclk = 1;
         if (i == fb_at)  fbclk = 1;
      end
   endtask

   // fast input period 8 clk, slow input period 32 clk offset by 4 clk.
   task automatic sat_run(input bit ref_fast, input int n, output int opp, output int nonmono);
      logic [15:0] prev;
      opp = 0; nonmono = 0; prev = vctrl;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         opp += ref_fast ? int'(down) : int'(up);
         if (ref_fast ? (vctrl < prev) : (vctrl > prev)) nonmono++;
         prev = vctrl;
         refclk = ref_fast ? ((i % 8) < 4) : ((i % 32) >= 4 && (i % 32) < 20);
         fbclk  = ref_fast ? ((i % 32) >= 4 && (i % 32) < 20) : ((i % 8) < 4);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ups, dns, bad;
      // reset held with toggling clocks
      push("v2code_ic", 32'd32768);
      pop_chk(32'(v2code(1500)));
      ups = 0; dns = 0; bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ups += int'(up); dns += int'(down); bad += int'(vctrl !== 16'd32768);
         refclk = i[0]; fbclk = i[1];
      end
      push("rst_up", 0); push("rst_dn", 0); push("rst_vctrl_bad", 0);
      pop_chk(ups); pop_chk(dns); pop_chk(bad);
      @(negedge clk);
      refclk = 0; fbclk = 0; rst = 0;
      repeat (2) @(negedge clk);
      // ref leads fb by 10
      push("lead_up", 10); push("lead_dn", 0); push("lead_vctrl", 33408);
      pulse_run(0, 10, 25, ups, dns);
      pop_chk(ups); pop_chk(dns); pop_chk(32'(vctrl));
      // fb leads ref by 5
      do_reset();
      push("lag_up", 0); push("lag_dn", 5); push("lag_vctrl", 32448);
      pulse_run(5, 0, 20, ups, dns);
      pop_chk(ups); pop_chk(dns); pop_chk(32'(vctrl));
      // coincident edges
      do_reset();
      push("both_up", 0); push("both_dn", 0); push("both_vctrl", 32768);
      pulse_run(0, 0, 15, ups, dns);
      pop_chk(ups); pop_chk(dns); pop_chk(32'(vctrl));
      // saturation high
      do_reset();
      push("sat_hi_dn", 0); push("sat_hi_nonmono", 0); push("sat_hi_vctrl", 65535);
      sat_run(1'b1, 1000, dns, bad);
      pop_chk(dns); pop_chk(bad); pop_chk(32'(vctrl));
      // saturation low
      do_reset();
      push("sat_lo_up", 0); push("sat_lo_nonmono", 0); push("sat_lo_vctrl", 0);
      sat_run(1'b0, 1000, ups, bad);
      pop_chk(ups); pop_chk(bad); pop_chk(32'(vctrl));
      // d=0 blocks assertion
      do_reset();
      d = 0;
      push("dlow_up", 0); push("dlow_vctrl", 32768);
      pulse_run(0, 1000, 15, ups, dns);
      pop_chk(ups); pop_chk(32'(vctrl));
      // d dropping while in UP holds state, then async reset mid-pump
      do_reset();
      push("up_set", 1); push("dhold_up", 1);
      refclk = 1;
      repeat (4) @(negedge clk);
      pop_chk(32'(up));
      d = 0;
      repeat (5) @(negedge clk);
      pop_chk(32'(up));
      #2 rst = 1;
      #1;
      push("arst_up", 0); push("arst_dn", 0); push("arst_vctrl", 32768);
      pop_chk(32'(up)); pop_chk(32'(down)); pop_chk(32'(vctrl));
      @(negedge clk);
      rst = 0; refclk = 0;
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
